// File: rtl/reg_file_param.sv
// Parametrised register file: one write port, two asynchronous read ports,
// optional hardwired-zero register 0, optional write-to-read bypass and a
// sequential clear sweep that zeroes one entry per cycle.
module reg_file_param #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned AW       = $clog2(DEPTH),
  parameter int unsigned ZERO_REG = 0,
  parameter int unsigned BYPASS   = 0
) (
  input  logic             clk,
  input  logic             RESET,
  input  logic [WIDTH-1:0] IN,
  input  logic [AW-1:0]    INaddr,
  input  logic             WRITE,
  input  logic [AW-1:0]    OUT1addr,
  input  logic [AW-1:0]    OUT2addr,
  output logic [WIDTH-1:0] OUT1,
  output logic [WIDTH-1:0] OUT2,
  input  logic             CLEAR,
  output logic             BUSY
);

  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [AW-1:0]    cnt_q, cnt_d;
  logic             sweep_c;
  logic             busy;
  logic             wr_en;
  logic [WIDTH-1:0] mem [DEPTH];

  assign busy = (state_q == ST_SWEEP);
  assign BUSY = busy;

  // Writes are dropped during a sweep and never land in a hardwired zero register.
  assign wr_en = WRITE && !busy && ((ZERO_REG == 0) || (INaddr != '0));

  // Sweep FSM state and counter registers.
  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Sweep FSM next state: a CLEAR in IDLE starts a DEPTH-cycle sweep, CLEAR during a sweep is ignored.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sweep_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (CLEAR) begin
          state_d = ST_SWEEP;
          cnt_d   = '0;
        end
      end
      ST_SWEEP: begin
        sweep_c = 1'b1;
        if (cnt_q == LAST_IDX) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Storage array: async clear on reset, sweep clear has priority over the (already gated) write.
  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (sweep_c) begin
      mem[cnt_q] <= '0;
    end else if (wr_en) begin
      mem[INaddr] <= IN;
    end
  end

  // Read port 1: array lookup, optional same-cycle bypass, forced zero for register 0.
  always_comb begin
    OUT1 = mem[OUT1addr];
    if ((BYPASS != 0) && wr_en && (INaddr == OUT1addr)) begin
      OUT1 = IN;
    end
    if ((ZERO_REG != 0) && (OUT1addr == '0)) begin
      OUT1 = '0;
    end
  end

  // Read port 2: identical to port 1.
  always_comb begin
    OUT2 = mem[OUT2addr];
    if ((BYPASS != 0) && wr_en && (INaddr == OUT2addr)) begin
      OUT2 = IN;
    end
    if ((ZERO_REG != 0) && (OUT2addr == '0)) begin
      OUT2 = '0;
    end
  end

endmodule

// File: tb/tb_reg_file_param.sv
// Directed self-checking bench for reg_file_param; four instances share the
// stimulus: plain, bypass, zero-register, and zero-register with bypass.
module tb_reg_file_param;

  logic       clk;
  logic       RESET;
  logic [7:0] IN;
  logic [2:0] INaddr;
  logic       WRITE;
  logic [2:0] OUT1addr;
  logic [2:0] OUT2addr;
  logic       CLEAR;

  logic [7:0] d_out1, d_out2, b_out1, b_out2, z_out1, z_out2, zb_out1, zb_out2;
  logic       d_busy, b_busy, z_busy, zb_busy;

  int checks;
  int errors;

  reg_file_param #(.WIDTH(8), .DEPTH(8), .ZERO_REG(0), .BYPASS(0)) dut (
    .clk(clk), .RESET(RESET), .IN(IN), .INaddr(INaddr), .WRITE(WRITE),
    .OUT1addr(OUT1addr), .OUT2addr(OUT2addr), .OUT1(d_out1), .OUT2(d_out2),
    .CLEAR(CLEAR), .BUSY(d_busy));

  reg_file_param #(.WIDTH(8), .DEPTH(8), .ZERO_REG(0), .BYPASS(1)) dut_b (
    .clk(clk), .RESET(RESET), .IN(IN), .INaddr(INaddr), .WRITE(WRITE),
    .OUT1addr(OUT1addr), .OUT2addr(OUT2addr), .OUT1(b_out1), .OUT2(b_out2),
    .CLEAR(CLEAR), .BUSY(b_busy));

  reg_file_param #(.WIDTH(8), .DEPTH(8), .ZERO_REG(1), .BYPASS(0)) dut_z (
    .clk(clk), .RESET(RESET), .IN(IN), .INaddr(INaddr), .WRITE(WRITE),
    .OUT1addr(OUT1addr), .OUT2addr(OUT2addr), .OUT1(z_out1), .OUT2(z_out2),
    .CLEAR(CLEAR), .BUSY(z_busy));

  reg_file_param #(.WIDTH(8), .DEPTH(8), .ZERO_REG(1), .BYPASS(1)) dut_zb (
    .clk(clk), .RESET(RESET), .IN(IN), .INaddr(INaddr), .WRITE(WRITE),
    .OUT1addr(OUT1addr), .OUT2addr(OUT2addr), .OUT1(zb_out1), .OUT2(zb_out2),
    .CLEAR(CLEAR), .BUSY(zb_busy));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance past the next rising edge and settle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [2:0] a, input logic [7:0] d);
    WRITE  = 1'b1;
    INaddr = a;
    IN     = d;
    step();
    WRITE  = 1'b0;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    #3;
    RESET = 1'b0;
    #3;
    checks++;
    if (d_busy !== 1'b0 || b_busy !== 1'b0 || z_busy !== 1'b0 || zb_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy got %b%b%b%b want 0000", d_busy, b_busy, z_busy, zb_busy);
    end
    for (int a = 0; a < 8; a++) begin
      OUT1addr = 3'(a);
      OUT2addr = 3'(7 - a);
      #1;
      checks++;
      if (d_out1 !== 8'h00 || d_out2 !== 8'h00 || b_out1 !== 8'h00 || zb_out2 !== 8'h00) begin
        errors++;
        $display("FAIL reset_read[%0d] got %h %h %h %h want 00", a, d_out1, d_out2, b_out1, zb_out2);
      end
    end
    @(negedge clk);
    RESET = 1'b1;
  endtask

  task automatic test_write_read();
    do_write(3'd5, 8'hFF);
    do_write(3'd1, 8'h95);
    OUT1addr = 3'd5;
    OUT2addr = 3'd1;
    #1;
    checks++;
    if (d_out1 !== 8'hFF || d_out2 !== 8'h95) begin
      errors++;
      $display("FAIL write_read got OUT1=%h OUT2=%h want FF 95", d_out1, d_out2);
    end
    checks++;
    if (zb_out1 !== 8'hFF || zb_out2 !== 8'h95) begin
      errors++;
      $display("FAIL write_read_zb got OUT1=%h OUT2=%h want FF 95", zb_out1, zb_out2);
    end
    for (int a = 0; a < 8; a++) begin
      if (a != 5 && a != 1) begin
        OUT1addr = 3'(a);
        #1;
        checks++;
        if (d_out1 !== 8'h00) begin
          errors++;
          $display("FAIL untouched_read[%0d] got %h want 00", a, d_out1);
        end
      end
    end
  endtask

  task automatic test_write_enable();
    WRITE  = 1'b0;
    IN     = 8'h77;
    INaddr = 3'd5;
    step();
    OUT1addr = 3'd5;
    OUT2addr = 3'd5;
    #1;
    checks++;
    if (d_out1 !== 8'hFF || d_out2 !== 8'hFF) begin
      errors++;
      $display("FAIL write_enable got OUT1=%h OUT2=%h want FF FF", d_out1, d_out2);
    end
  endtask

  task automatic test_bypass();
    WRITE    = 1'b1;
    INaddr   = 3'd3;
    IN       = 8'hA5;
    OUT1addr = 3'd3;
    OUT2addr = 3'd5;
    #1;
    checks++;
    if (b_out1 !== 8'hA5) begin
      errors++;
      $display("FAIL bypass_pre got %h want A5", b_out1);
    end
    checks++;
    if (d_out1 !== 8'h00 || b_out2 !== 8'hFF) begin
      errors++;
      $display("FAIL no_bypass_pre got OUT1=%h OUT2b=%h want 00 FF", d_out1, b_out2);
    end
    step();
    WRITE = 1'b0;
    #1;
    checks++;
    if (d_out1 !== 8'hA5 || b_out1 !== 8'hA5) begin
      errors++;
      $display("FAIL bypass_post got %h %h want A5 A5", d_out1, b_out1);
    end
  endtask

  task automatic test_zero_reg();
    WRITE    = 1'b1;
    INaddr   = 3'd0;
    IN       = 8'h5A;
    OUT1addr = 3'd0;
    OUT2addr = 3'd0;
    #1;
    checks++;
    if (zb_out1 !== 8'h00 || zb_out2 !== 8'h00) begin
      errors++;
      $display("FAIL zero_reg_bypass got %h %h want 00", zb_out1, zb_out2);
    end
    checks++;
    if (b_out1 !== 8'h5A) begin
      errors++;
      $display("FAIL bypass_r0 got %h want 5A", b_out1);
    end
    step();
    WRITE = 1'b0;
    #1;
    checks++;
    if (z_out1 !== 8'h00 || zb_out1 !== 8'h00) begin
      errors++;
      $display("FAIL zero_reg_post got %h %h want 00", z_out1, zb_out1);
    end
    checks++;
    if (d_out1 !== 8'h5A) begin
      errors++;
      $display("FAIL plain_r0 got %h want 5A", d_out1);
    end
  endtask

  task automatic test_clear_sweep();
    int n;
    for (int a = 0; a < 8; a++) begin
      do_write(3'(a), 8'h10 + 8'(a));
    end
    CLEAR = 1'b1;
    step();
    CLEAR    = 1'b0;
    OUT1addr = 3'd0;
    #1;
    checks++;
    if (d_busy !== 1'b1 || d_out1 !== 8'h10) begin
      errors++;
      $display("FAIL sweep_start got BUSY=%b r0=%h want 1 10", d_busy, d_out1);
    end
    step();
    step();
    step();
    OUT1addr = 3'd0;
    OUT2addr = 3'd1;
    #1;
    checks++;
    if (d_out1 !== 8'h00 || d_out2 !== 8'h00) begin
      errors++;
      $display("FAIL sweep_r0_r1 got %h %h want 00 00", d_out1, d_out2);
    end
    OUT1addr = 3'd2;
    OUT2addr = 3'd3;
    #1;
    checks++;
    if (d_out1 !== 8'h00 || d_out2 !== 8'h13) begin
      errors++;
      $display("FAIL sweep_r2_r3 got %h %h want 00 13", d_out1, d_out2);
    end
    WRITE    = 1'b1;
    INaddr   = 3'd7;
    IN       = 8'hEE;
    CLEAR    = 1'b1;
    OUT1addr = 3'd7;
    #1;
    checks++;
    if (b_out1 !== 8'h17) begin
      errors++;
      $display("FAIL busy_bypass got %h want 17", b_out1);
    end
    step();
    CLEAR  = 1'b0;
    INaddr = 3'd1;
    step();
    WRITE = 1'b0;
    n = 0;
    while (d_busy === 1'b1 && n < 20) begin
      step();
      n++;
    end
    checks++;
    if (n != 3) begin
      errors++;
      $display("FAIL sweep_length got %0d remaining cycles want 3", n);
    end
    for (int a = 0; a < 8; a++) begin
      OUT1addr = 3'(a);
      OUT2addr = 3'(a);
      #1;
      checks++;
      if (d_out1 !== 8'h00 || b_out2 !== 8'h00 || z_out1 !== 8'h00) begin
        errors++;
        $display("FAIL post_sweep[%0d] got %h %h %h want 00", a, d_out1, b_out2, z_out1);
      end
      if (a == 3) step();
    end
  endtask

  task automatic test_reset_mid_sweep();
    do_write(3'd4, 8'h55);
    CLEAR = 1'b1;
    step();
    CLEAR = 1'b0;
    step();
    step();
    step();
    step();
    OUT1addr = 3'd4;
    #1;
    checks++;
    if (d_busy !== 1'b1 || d_out1 !== 8'h55) begin
      errors++;
      $display("FAIL pre_reset got BUSY=%b r4=%h want 1 55", d_busy, d_out1);
    end
    #1;
    RESET = 1'b0;
    #1;
    checks++;
    if (d_busy !== 1'b0 || b_busy !== 1'b0 || d_out1 !== 8'h00) begin
      errors++;
      $display("FAIL mid_reset got BUSY=%b r4=%h want 0 00", d_busy, d_out1);
    end
    for (int a = 0; a < 8; a++) begin
      OUT1addr = 3'(a);
      OUT2addr = 3'(a);
      #1;
      checks++;
      if (d_out1 !== 8'h00 || b_out2 !== 8'h00) begin
        errors++;
        $display("FAIL mid_reset_read[%0d] got %h %h want 00", a, d_out1, b_out2);
      end
    end
    @(negedge clk);
    RESET = 1'b1;
    do_write(3'd2, 8'h3C);
    OUT1addr = 3'd2;
    OUT2addr = 3'd2;
    #1;
    checks++;
    if (d_out1 !== 8'h3C || zb_out2 !== 8'h3C || d_busy !== 1'b0) begin
      errors++;
      $display("FAIL after_reset got %h %h BUSY=%b want 3C 3C 0", d_out1, zb_out2, d_busy);
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    RESET    = 1'b1;
    IN       = 8'h00;
    INaddr   = 3'd0;
    WRITE    = 1'b0;
    OUT1addr = 3'd0;
    OUT2addr = 3'd0;
    CLEAR    = 1'b0;
    test_reset();
    test_write_read();
    test_write_enable();
    test_bypass();
    test_zero_reg();
    test_clear_sweep();
    test_reset_mid_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
